// File: rtl/cim_pkg.sv
// Shared types for the CIM access arbiter and its helpers.
package cim_pkg;

  typedef enum logic [1:0] {
    s_cim_arb_idle  = 2'd0,
    s_cim_arb_grant = 2'd1,
    s_cim_arb_busy  = 2'd2
  } t_cim_arb_state;

endpackage

// File: rtl/cim_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 valid
);

  logic [IDX_WIDTH-1:0] cand_s;

  // Scan from the priority pointer and latch onto the first request seen.
  always_comb begin
    idx    = {IDX_WIDTH{1'b0}};
    valid  = 1'b0;
    cand_s = {IDX_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_WIDTH'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand_s]) begin
        idx   = cand_s;
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/cim_arbiter.sv
// Round-robin owner arbiter time-sharing one CIM tile group between layer controllers.
// The grant is held across a whole CIM job and moves on only through an idle cycle.
module cim_arbiter
  import cim_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ-1:0]            i_start,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_req_cim_ready,
  output logic                          o_cim_we,
  output logic                          o_cim_start,
  output logic [ADDR_WIDTH-1:0]         o_cim_addr,
  output logic [IDX_WIDTH-1:0]          o_owner,
  input  logic                          i_cim_ready
);

  localparam logic [NUM_REQ-1:0]   GNT_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

  t_cim_arb_state       state_r, state_nx_s;
  logic [IDX_WIDTH-1:0] owner_r, owner_nx_s;
  logic [IDX_WIDTH-1:0] ptr_r, ptr_nx_s;
  logic [NUM_REQ-1:0]   gnt_r, gnt_nx_s;
  logic [IDX_WIDTH-1:0] pick_idx_s;
  logic                 pick_valid_s;

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // State, owner, priority pointer and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= s_cim_arb_idle;
      owner_r <= {IDX_WIDTH{1'b0}};
      ptr_r   <= {IDX_WIDTH{1'b0}};
      gnt_r   <= {NUM_REQ{1'b0}};
    end else begin
      state_r <= state_nx_s;
      owner_r <= owner_nx_s;
      ptr_r   <= ptr_nx_s;
      gnt_r   <= gnt_nx_s;
    end
  end

  // Next-state logic; a CIM ready drop in GRANT means it accepted a start.
  always_comb begin
    state_nx_s = state_r;
    owner_nx_s = owner_r;
    ptr_nx_s   = ptr_r;
    gnt_nx_s   = gnt_r;
    case (state_r)
      s_cim_arb_idle: begin
        if (pick_valid_s && i_cim_ready) begin
          state_nx_s = s_cim_arb_grant;
          owner_nx_s = pick_idx_s;
          gnt_nx_s   = GNT_LSB << pick_idx_s;
        end else begin
          gnt_nx_s   = {NUM_REQ{1'b0}};
        end
      end
      s_cim_arb_grant: begin
        if (!i_cim_ready) begin
          state_nx_s = s_cim_arb_busy;
        end else if (!i_req[owner_r]) begin
          state_nx_s = s_cim_arb_idle;
          ptr_nx_s   = (owner_r == LAST_IDX) ? {IDX_WIDTH{1'b0}} : owner_r + IDX_WIDTH'(1);
          owner_nx_s = {IDX_WIDTH{1'b0}};
          gnt_nx_s   = {NUM_REQ{1'b0}};
        end else begin
          state_nx_s = s_cim_arb_grant;
        end
      end
      s_cim_arb_busy: begin
        if (i_cim_ready) begin
          state_nx_s = s_cim_arb_grant;
        end else begin
          state_nx_s = s_cim_arb_busy;
        end
      end
      default: begin
        state_nx_s = s_cim_arb_idle;
        owner_nx_s = {IDX_WIDTH{1'b0}};
        gnt_nx_s   = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // Route only the owner's CIM controls; everyone else sees the CIM as not ready.
  always_comb begin
    o_cim_we        = 1'b0;
    o_cim_start     = 1'b0;
    o_cim_addr      = {ADDR_WIDTH{1'b0}};
    o_req_cim_ready = {NUM_REQ{1'b0}};
    case (state_r)
      s_cim_arb_grant: begin
        o_cim_we                 = i_we[owner_r];
        o_cim_start              = i_start[owner_r];
        o_cim_addr               = i_addr[owner_r*ADDR_WIDTH +: ADDR_WIDTH];
        o_req_cim_ready[owner_r] = i_cim_ready;
      end
      s_cim_arb_busy: begin
        o_cim_we    = i_we[owner_r];
        o_cim_start = i_start[owner_r];
        o_cim_addr  = i_addr[owner_r*ADDR_WIDTH +: ADDR_WIDTH];
      end
      default: begin
        o_cim_we    = 1'b0;
        o_cim_start = 1'b0;
      end
    endcase
  end

  assign o_gnt   = gnt_r;
  assign o_owner = owner_r;

endmodule

// File: tb/tb_cim_arbiter.sv
// Directed self-checking bench for cim_arbiter (4 requesters, 4-bit addresses).
module tb_cim_arbiter;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  i_req, i_we, i_start;
  logic [NR*AW-1:0] i_addr;
  logic [NR-1:0]  o_gnt, o_req_cim_ready;
  logic           o_cim_we, o_cim_start;
  logic [AW-1:0]  o_cim_addr;
  logic [IW-1:0]  o_owner;
  logic           i_cim_ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cim_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_we            (i_we),
    .i_start         (i_start),
    .i_addr          (i_addr),
    .o_gnt           (o_gnt),
    .o_req_cim_ready (o_req_cim_ready),
    .o_cim_we        (o_cim_we),
    .o_cim_start     (o_cim_start),
    .o_cim_addr      (o_cim_addr),
    .o_owner         (o_owner),
    .i_cim_ready     (i_cim_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = '0; i_we = '0; i_start = '0; i_addr = '0; i_cim_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    vec_cnt++; if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL reset_gnt: got %b want 0000", o_gnt); end
    vec_cnt++; if (o_owner !== 2'd0) begin err_cnt++; $display("FAIL reset_owner: got %0d want 0", o_owner); end
    vec_cnt++; if ({o_cim_we, o_cim_start, o_cim_addr} !== 6'b0) begin err_cnt++; $display("FAIL reset_cim: got we=%b st=%b addr=%0d want 0", o_cim_we, o_cim_start, o_cim_addr); end
    vec_cnt++; if (o_req_cim_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_rdy: got %b want 0000", o_req_cim_ready); end
  endtask

  task automatic test_single();
    i_req = 4'b0001; i_we = 4'b0001; i_addr = 16'h0005;
    #1;
    vec_cnt++; if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL single_pre_gnt: got %b want 0000", o_gnt); end
    step();
    vec_cnt++; if (o_gnt !== 4'b0001) begin err_cnt++; $display("FAIL single_gnt: got %b want 0001", o_gnt); end
    vec_cnt++; if (o_owner !== 2'd0) begin err_cnt++; $display("FAIL single_owner: got %0d want 0", o_owner); end
    vec_cnt++; if (o_cim_we !== 1'b1 || o_cim_addr !== 4'd5) begin err_cnt++; $display("FAIL single_mux: got we=%b addr=%0d want we=1 addr=5", o_cim_we, o_cim_addr); end
    vec_cnt++; if (o_req_cim_ready !== 4'b0001) begin err_cnt++; $display("FAIL single_rdy: got %b want 0001", o_req_cim_ready); end
    i_req = '0; i_we = '0; i_addr = '0;
    step();
    vec_cnt++; if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL single_release: got %b want 0000", o_gnt); end
  endtask

  task automatic test_busy();
    i_req = 4'b0001;
    step();
    i_start = 4'b0001;
    #1;
    vec_cnt++; if (o_gnt !== 4'b0001 || o_cim_start !== 1'b1) begin err_cnt++; $display("FAIL busy_start: got gnt=%b st=%b want 0001/1", o_gnt, o_cim_start); end
    step();
    vec_cnt++; if (o_gnt !== 4'b0001 || o_req_cim_ready !== 4'b0001) begin err_cnt++; $display("FAIL busy_hold_grant: got gnt=%b rdy=%b want 0001/0001", o_gnt, o_req_cim_ready); end
    i_cim_ready = 1'b0; i_start = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) i_req = '0;
      #1;
      vec_cnt++; if (o_gnt !== 4'b0001 || o_req_cim_ready !== 4'b0000) begin err_cnt++; $display("FAIL busy_cyc%0d: got gnt=%b rdy=%b want 0001/0000", i, o_gnt, o_req_cim_ready); end
    end
    i_cim_ready = 1'b1;
    #1;
    vec_cnt++; if (o_req_cim_ready !== 4'b0000) begin err_cnt++; $display("FAIL busy_last: got rdy=%b want 0000", o_req_cim_ready); end
    step();
    vec_cnt++; if (o_gnt !== 4'b0001 || o_req_cim_ready !== 4'b0001) begin err_cnt++; $display("FAIL busy_back_grant: got gnt=%b rdy=%b want 0001/0001", o_gnt, o_req_cim_ready); end
    step();
    vec_cnt++; if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL busy_release: got %b want 0000", o_gnt); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_gnt;
    rst = 1'b1; step(); rst = 1'b0;
    i_req = 4'b1111; i_cim_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % NR);
      step();
      vec_cnt++; if (o_gnt !== exp_gnt || o_owner !== IW'(k % NR)) begin err_cnt++; $display("FAIL rr_gnt%0d: got gnt=%b owner=%0d want %b/%0d", k, o_gnt, o_owner, exp_gnt, k % NR); end
      i_start = exp_gnt;
      step();
      i_start = '0; i_cim_ready = 1'b0;
      step();
      i_cim_ready = 1'b1;
      step();
      i_req = i_req & ~exp_gnt;
      step();
      vec_cnt++; if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL rr_gap%0d: got %b want 0000", k, o_gnt); end
      i_req = 4'b1111;
    end
    i_req = '0;
    step();
  endtask

  task automatic test_isolation();
    i_req = 4'b0100;
    step();
    i_req = 4'b0110; i_start = 4'b0010; i_we = 4'b0010; i_addr = 16'h0970;
    #1;
    vec_cnt++; if (o_owner !== 2'd2 || o_gnt !== 4'b0100) begin err_cnt++; $display("FAIL iso_owner: got owner=%0d gnt=%b want 2/0100", o_owner, o_gnt); end
    vec_cnt++; if (o_cim_start !== 1'b0 || o_cim_we !== 1'b0) begin err_cnt++; $display("FAIL iso_ctrl: got st=%b we=%b want 0/0", o_cim_start, o_cim_we); end
    vec_cnt++; if (o_cim_addr !== 4'd9) begin err_cnt++; $display("FAIL iso_addr: got %0d want 9", o_cim_addr); end
    vec_cnt++; if (o_req_cim_ready !== 4'b0100) begin err_cnt++; $display("FAIL iso_rdy: got %b want 0100", o_req_cim_ready); end
    i_req = '0; i_start = '0; i_we = '0; i_addr = '0;
    step();
  endtask

  task automatic test_idle_not_ready();
    i_cim_ready = 1'b0; i_req = 4'b0100;
    step(); step();
    vec_cnt++; if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL nrdy_hold: got %b want 0000", o_gnt); end
    i_cim_ready = 1'b1;
    #1;
    vec_cnt++; if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL nrdy_same_cycle: got %b want 0000", o_gnt); end
    step();
    vec_cnt++; if (o_gnt !== 4'b0100 || o_owner !== 2'd2) begin err_cnt++; $display("FAIL nrdy_gnt: got gnt=%b owner=%0d want 0100/2", o_gnt, o_owner); end
  endtask

  task automatic test_reset_mid_busy();
    i_start = 4'b0100; i_addr = 16'h0300;
    step();
    i_start = '0; i_cim_ready = 1'b0;
    step();
    vec_cnt++; if (o_gnt !== 4'b0100 || o_req_cim_ready !== 4'b0000 || o_cim_addr !== 4'd3) begin err_cnt++; $display("FAIL rstb_busy: got gnt=%b rdy=%b addr=%0d want 0100/0000/3", o_gnt, o_req_cim_ready, o_cim_addr); end
    rst = 1'b1; i_req = 4'b1010; i_cim_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
    vec_cnt++; if (o_gnt !== 4'b0000 || o_owner !== 2'd0) begin err_cnt++; $display("FAIL rstb_drop: got gnt=%b owner=%0d want 0000/0", o_gnt, o_owner); end
    vec_cnt++; if (o_cim_addr !== 4'd0 || o_req_cim_ready !== 4'b0000) begin err_cnt++; $display("FAIL rstb_cim: got addr=%0d rdy=%b want 0/0000", o_cim_addr, o_req_cim_ready); end
    step();
    vec_cnt++; if (o_gnt !== 4'b0010 || o_owner !== 2'd1) begin err_cnt++; $display("FAIL rstb_next: got gnt=%b owner=%0d want 0010/1", o_gnt, o_owner); end
    i_req = '0; i_addr = '0;
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_busy();
    test_round_robin();
    test_isolation();
    test_idle_not_ready();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
